// File: rtl/ave8_pkg.sv
// Shared widths, defaults and FSM encoding for the ave8 interpolator.
package ave8_pkg;
    localparam int LOG2_FACTOR_DEF = 3;
    localparam int SAMPLE_W        = 8;
    localparam int DIFF_W          = SAMPLE_W + 1;
    localparam int ACC_W           = SAMPLE_W + LOG2_FACTOR_DEF;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;
endpackage

// File: rtl/ave8_interp_step.sv
// Interpolation datapath: loads prev*8 and cur-prev, then steps acc by diff.
module ave8_interp_step
    import ave8_pkg::*;
#(
    parameter int LOG2_FACTOR = LOG2_FACTOR_DEF
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                load,
    input  logic                step,
    input  logic [SAMPLE_W-1:0] base,
    input  logic [SAMPLE_W-1:0] cur,
    output logic [SAMPLE_W-1:0] interp_ret
);
    localparam int AW = SAMPLE_W + LOG2_FACTOR;

    logic [DIFF_W-1:0] diff;
    logic [AW-1:0]     acc;
    logic [AW-1:0]     acc_nxt;
    logic [DIFF_W-1:0] diff_nxt;

    // acc stays a convex combination of two samples, so it can never wrap
    always_comb begin
        acc_nxt  = acc;
        diff_nxt = diff;
        if (load) begin
            acc_nxt  = AW'(base) << LOG2_FACTOR;
            diff_nxt = {1'b0, cur} - {1'b0, base};
        end else if (step) begin
            acc_nxt = acc + {{(AW-DIFF_W){diff[DIFF_W-1]}}, diff};
        end
    end

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            diff       <= '0;
            acc        <= '0;
            interp_ret <= '0;
        end else begin
            diff <= diff_nxt;
            acc  <= acc_nxt;
            if (load || step)
                interp_ret <= acc_nxt[AW-1 -: SAMPLE_W];
        end
    end
endmodule

// File: rtl/ave8_interp.sv
// Upsamples ave8 coarse samples by 2^LOG2_FACTOR with linear interpolation.
module ave8_interp
    import ave8_pkg::*;
#(
    parameter int LOG2_FACTOR = LOG2_FACTOR_DEF
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in0,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W-1:0] interp_ret
);
    localparam logic [LOG2_FACTOR-1:0] K_LAST = '1;

    state_t               state;
    logic [LOG2_FACTOR-1:0] k;
    logic [SAMPLE_W-1:0]  prev;
    logic [SAMPLE_W-1:0]  cur;
    logic                 out_xfer;
    logic                 last_xfer;
    logic                 accept;
    logic [SAMPLE_W-1:0]  base;

    assign out_valid = (state == EMIT);
    assign out_xfer  = out_valid & out_ready;
    assign last_xfer = out_xfer & (k == K_LAST);
    // A new sample may slip in on the final fine transfer so bursts chain without a bubble
    assign in_ready  = RESET & ((state == IDLE) | last_xfer);
    assign accept    = in_valid & in_ready;
    assign base      = last_xfer ? cur : prev;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            k     <= '0;
            prev  <= '0;
            cur   <= '0;
        end else begin
            if (last_xfer)
                prev <= cur;
            if (accept) begin
                cur   <= in0;
                k     <= '0;
                state <= EMIT;
            end else if (last_xfer) begin
                state <= IDLE;
            end else if (out_xfer) begin
                k <= k + 1'b1;
            end
        end
    end

    ave8_interp_step #(.LOG2_FACTOR(LOG2_FACTOR)) u_step (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .load       (accept),
        .step       (out_xfer & (k != K_LAST)),
        .base       (base),
        .cur        (in0),
        .interp_ret (interp_ret)
    );
endmodule

// File: tb/tb_ave8_interp.sv
// Randomised bench for ave8_interp against a per-sample interpolation model.
module tb_ave8_interp;
    logic       CLOCK = 0;
    logic       RESET = 0;
    logic       in_valid = 0;
    logic       in_ready;
    logic [7:0] in0 = 0;
    logic       out_valid;
    logic       out_ready = 0;
    logic [7:0] interp_ret;

    int total = 0;
    int bad   = 0;

    logic [7:0] src_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int m_prev = 0;
    int nout, stall_bad, rdy_bad, gaps, acc_cyc, out_cyc;
    bit timeout;

    ave8_interp #(.LOG2_FACTOR(3)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready),
        .in0(in0), .out_valid(out_valid), .out_ready(out_ready), .interp_ret(interp_ret)
    );

    always #5 CLOCK = ~CLOCK;

    // model: fine sample k = floor((8*prev + k*(cur-prev))/8); never negative
    task automatic send(input int cur);
        src_q.push_back(8'(cur));
        for (int k = 0; k < 8; k++)
            exp_q.push_back(8'((8 * m_prev + k * (cur - m_prev)) / 8));
        m_prev = cur;
    endtask

    task automatic stream(input bit rnd_rdy, input bit rnd_vld, input int budget);
        int cyc = 0;
        logic [7:0] last_ret = 0;
        bit stalled = 0;
        nout = 0; stall_bad = 0; rdy_bad = 0; gaps = 0;
        acc_cyc = -1; out_cyc = -1; timeout = 0;
        got_q.delete();
        forever begin
            @(negedge CLOCK);
            if (src_q.size() == 0 && !out_valid) break;
            if (cyc >= budget) begin timeout = 1; break; end
            out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            in_valid  = (src_q.size() > 0) && (rnd_vld ? 1'($urandom_range(0, 1)) : 1'b1);
            in0       = in_valid ? src_q[0] : 8'($urandom);
            #1;
            if (stalled && interp_ret !== last_ret) stall_bad++;
            if (nout > 0 && !out_valid && src_q.size() > 0) gaps++;
            if (out_valid && in_ready && (nout % 8) != 7) rdy_bad++;
            if (out_valid && out_ready) begin
                if (out_cyc < 0) out_cyc = cyc;
                got_q.push_back(interp_ret);
                nout++;
            end
            if (in_valid && in_ready) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                void'(src_q.pop_front());
            end
            stalled  = out_valid && !out_ready;
            last_ret = interp_ret;
            cyc++;
        end
        in_valid = 0;
    endtask

    task automatic test_reset;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b want=0", in_ready); end
        total++; if (interp_ret !== 8'd0) begin bad++; $display("FAIL rst_ret got=%0d want=0", interp_ret); end
        @(negedge CLOCK); RESET = 1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rel_out_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_ramp;
        int vals[3] = '{80, 0, 40};
        foreach (vals[j]) begin
            send(vals[j]);
            stream(0, 0, 100);
            total++; if (timeout) begin bad++; $display("FAIL ramp_timeout sample=%0d", vals[j]); end
            total++; if (out_cyc - acc_cyc !== 1) begin bad++; $display("FAIL ramp_latency got=%0d want=1", out_cyc - acc_cyc); end
            total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL ramp_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL ramp[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_rounding;
        int vals[3] = '{1, 0, 255};
        foreach (vals[j]) begin
            send(vals[j]);
            stream(0, 0, 100);
            total++; if (timeout) begin bad++; $display("FAIL round_timeout sample=%0d", vals[j]); end
            total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL round_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL round[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_back_to_back;
        for (int pass = 0; pass < 2; pass++) begin
            send(16); send(32);
            stream(pass == 1, 0, 200);
            total++; if (timeout) begin bad++; $display("FAIL b2b_timeout pass=%0d", pass); end
            total++; if (pass == 0 && gaps != 0) begin bad++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
            total++; if (rdy_bad != 0) begin bad++; $display("FAIL b2b_in_ready got=%0d want=0", rdy_bad); end
            total++; if (stall_bad != 0) begin bad++; $display("FAIL b2b_stall got=%0d want=0", stall_bad); end
            total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
            for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
                total++; if (got_q[i] !== exp_q[i]) begin bad++; $display("FAIL b2b[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]); end
            end
            exp_q.delete();
        end
    endtask

    task automatic test_reset_mid;
        int want3;
        @(negedge CLOCK);
        out_ready = 1; in_valid = 1; in0 = 8'd200;
        @(negedge CLOCK);
        in_valid = 0;
        repeat (3) @(negedge CLOCK);
        want3 = (8 * m_prev + 3 * (200 - m_prev)) / 8;
        total++; if (out_valid !== 1'b1 || interp_ret !== 8'(want3)) begin
            bad++; $display("FAIL mid_k3 got=%0d/%b want=%0d/1", interp_ret, out_valid, want3);
        end
        #2 RESET = 0; #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", out_valid); end
        total++; if (interp_ret !== 8'd0) begin bad++; $display("FAIL mid_rst_ret got=%0d want=0", interp_ret); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready got=%b want=0", in_ready); end
        @(negedge CLOCK); @(negedge CLOCK);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_hold_valid got=%b want=0", out_valid); end
        RESET = 1;
        m_prev = 0;
        exp_q.delete();
        send(8);
        stream(0, 0, 100);
        total++; if (got_q.size() != 8) begin bad++; $display("FAIL mid_count got=%0d want=8", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < 8; i++) begin
            total++; if (got_q[i] !== 8'(i)) begin bad++; $display("FAIL mid[%0d] got=%0d want=%0d", i, got_q[i], i); end
        end
        exp_q.delete();
    endtask

    task automatic test_random;
        int shown = 0;
        for (int n = 0; n < 1000; n++) send(int'($urandom_range(0, 255)));
        stream(1, 1, 40000);
        total++; if (timeout) begin bad++; $display("FAIL rand_timeout outs=%0d", nout); end
        total++; if (stall_bad != 0) begin bad++; $display("FAIL rand_stall got=%0d want=0", stall_bad); end
        total++; if (rdy_bad != 0) begin bad++; $display("FAIL rand_in_ready got=%0d want=0", rdy_bad); end
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            total++;
            if (got_q[i] !== exp_q[i]) begin
                bad++;
                if (shown < 10) $display("FAIL rand[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]);
                shown++;
            end
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_ramp;
        test_rounding;
        test_back_to_back;
        test_reset_mid;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ave8_interp.md
AVE8_INTERP -- requirements
Module: ave8_interp

Interface
REQ-001 SHALL have parameter LOG2_FACTOR, default 3, meaning log2 of the upsample factor; only the value 3 (factor 8) is required.
REQ-002 SHALL have port CLOCK  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port RESET  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  in0 carries a new coarse sample.
REQ-005 SHALL have port in_ready  output  1  block accepts in0 this cycle.
REQ-006 SHALL have port in0  input  8  unsigned coarse sample, as produced by the ave8 averager.
REQ-007 SHALL have port out_valid  output  1  interp_ret holds a valid fine sample.
REQ-008 SHALL have port out_ready  input  1  downstream consumes interp_ret this cycle.
REQ-009 SHALL have port interp_ret  output  8  unsigned interpolated fine sample, driven from a register.

Function
REQ-010 SHALL transfer an input only when in_valid and in_ready are both high at a rising edge.
REQ-011 SHALL transfer an output only when out_valid and out_ready are both high at a rising edge.
REQ-012 SHALL keep prev, an 8-bit copy of the last accepted sample; prev is 0 after reset.
REQ-013 SHALL implement a 2-state FSM: IDLE (in_ready=1, out_valid=0) and EMIT (out_valid=1).
REQ-014 SHALL, on acceptance of sample cur, perform these updates: diff = cur - prev, as a 9-bit signed value; acc = prev*8, as an 11-bit unsigned value; k = 0; state -> EMIT.
REQ-015 SHALL drive interp_ret = acc[10:3] in EMIT; the first fine sample is valid the cycle after acceptance (latency 1).
REQ-016 SHALL produce fine sample k (k = 0..7) as floor((8*prev + k*diff)/8).
REQ-017 SHALL, on each output transfer with k < 7, update acc += sign-extended diff and k += 1.
REQ-018 SHALL, on the output transfer with k = 7, update prev = cur; the FSM goes to IDLE unless REQ-019 applies.
REQ-019 SHALL assert in_ready in EMIT when k = 7 and out_ready = 1, so a new sample is accepted in the same cycle as the last transfer.
REQ-020 SHALL, in the REQ-019 case, use the updated prev (old cur) for the new diff and acc; the FSM stays in EMIT with k = 0, giving one fine sample per cycle with no bubble.
REQ-021 SHALL hold interp_ret, k and acc stable while out_valid = 1 and out_ready = 0 (back-pressure).
REQ-022 SHALL ignore in0 and in_valid whenever in_ready = 0.
REQ-023 SHALL keep acc within 0..2040 and never wrap it, because the result is a convex combination of two 8-bit values.
REQ-024 SHALL require no saturation logic, because interp_ret always lies between prev and cur inclusive.

Reset
REQ-025 SHALL, on RESET low, immediately clear state to IDLE and set prev, acc, diff, k and interp_ret to 0.
REQ-026 SHALL hold out_valid = 0 and in_ready = 0 while RESET is low.
REQ-027 SHALL raise in_ready in the first cycle after RESET deasserts.
REQ-028 SHALL, on reset mid-EMIT, discard the partial burst with no further outputs for the aborted sample.

Structure
REQ-029 SHALL place LOG2_FACTOR default, FSM state encodings (IDLE = 0, EMIT = 1) and widths (sample 8, diff 9, acc 11) in shared package ave8_pkg.
REQ-030 SHALL isolate the datapath in sub-module ave8_interp_step: load/step control, acc, diff, interp_ret register.
REQ-031 SHALL keep the FSM, counter k and handshakes in ave8_interp.

Verification
REQ-032 Ramp up: after reset, send 80 with out_ready=1 -> interp_ret = 0,10,20,30,40,50,60,70 on 8 consecutive cycles starting one cycle after acceptance.
REQ-033 Ramp down: then send 0 -> 80,70,60,50,40,30,20,10; the next sample with prev = 0 starts from 0.
REQ-034 Rounding: prev=1, send 0 -> 1,0,0,0,0,0,0,0; prev=0, send 255 -> 0,31,63,95,127,159,191,223.
REQ-035 Back-to-back and back-pressure: hold in_valid=1 with samples 16,32 -> 16 fine samples with no gap, in_ready high only on the k=7 cycles; a random out_ready pattern gives the same sequence, and interp_ret never changes while stalled.
REQ-036 Reset mid-burst: assert RESET at k=3 of sample 200 -> out_valid=0 and interp_ret=0 immediately; after release, sending 8 gives 0,1,2,3,4,5,6,7.
REQ-037 Chained with ave8: ave8 output drives in0 -> output matches a reference model implementing REQ-016 over 1000 random samples.
